// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial edge sampler
//
// Holds the sampler FSM state encoding, the active-edge select constants and
// the chip-select polarity constants used by serial_edge_sampler.
package serial_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;

  localparam int CS_POL_HIGH = 0;
  localparam int CS_POL_LOW  = 1;

endpackage

// File: rtl/serial_edge_sampler_if.sv
// rtl/serial_edge_sampler_if.sv - bus and strobe bundle of the serial edge sampler
//
// Ports (signals):
//   en, bus_clk, bus_data, bus_cs            : driven by master, sampled by slave
//   read_sig, data_bit, frame_start,
//   frame_end, frame_active, bit_count,
//   overflow                                 : driven by slave (the sampler)
// CNT_W must equal $clog2(MAX_BITS+1) of the attached sampler.
interface serial_edge_sampler_if #(
  parameter int CNT_W = 6
);

  logic             en;
  logic             bus_clk;
  logic             bus_data;
  logic             bus_cs;
  logic             read_sig;
  logic             data_bit;
  logic             frame_start;
  logic             frame_end;
  logic             frame_active;
  logic [CNT_W-1:0] bit_count;
  logic             overflow;

  modport master (
    output en, bus_clk, bus_data, bus_cs,
    input  read_sig, data_bit, frame_start, frame_end, frame_active, bit_count, overflow
  );

  modport slave (
    input  en, bus_clk, bus_data, bus_cs,
    output read_sig, data_bit, frame_start, frame_end, frame_active, bit_count, overflow
  );

endinterface

// File: rtl/serial_line_sync.sv
// rtl/serial_line_sync.sv - one-bit synchronizer chain with optional glitch filter
//
// Optional feature macro: SERIAL_GLITCH_FILTER_EN (adds the stable-cycle filter).
// Ports:
//   sys_clk : system clock
//   rst     : synchronous active-high reset, loads RST_VAL into every stage
//   line_i  : asynchronous input line
//   line_o  : synchronized (and, with the filter, debounced) line
module serial_line_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0,
  parameter int   FILTER_LEN  = 3
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("serial_line_sync: SYNC_STAGES must be 2..4");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("serial_line_sync: FILTER_LEN must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end
  end

`ifdef SERIAL_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic              filt_q;
  logic [FCNT_W-1:0] fcnt_q;

  // The filtered level follows only after the synced level has disagreed
  // with it for FILTER_LEN consecutive cycles; any agreement restarts the run.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      filt_q <= RST_VAL;
      fcnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign line_o = filt_q;
`else
  assign line_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/serial_edge_sampler.sv
// rtl/serial_edge_sampler.sv - serial read-path front end: sync, edge detect, framing
//
// Optional feature macro: SERIAL_GLITCH_FILTER_EN (glitch filter on all three lines).
// Ports:
//   sys_clk : system clock
//   rst     : synchronous active-high reset
//   sif     : serial_edge_sampler_if.slave
//             in : en, bus_clk, bus_data, bus_cs
//             out: read_sig, data_bit, frame_start, frame_end, frame_active,
//                  bit_count[CNT_W-1:0], overflow
module serial_edge_sampler
  import serial_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   SAMPLE_EDGE   = 0,
  parameter logic CLK_IDLE      = 1'b0,
  parameter int   CS_ACTIVE_LOW = 1,
  parameter int   MAX_BITS      = 32,
  parameter int   FILTER_LEN    = 3
) (
  input logic                 sys_clk,
  input logic                 rst,
  serial_edge_sampler_if.slave sif
);

  localparam int   CNT_W   = $clog2(MAX_BITS + 1);
  localparam logic CS_IDLE = (CS_ACTIVE_LOW == CS_POL_LOW);
`ifdef SERIAL_GLITCH_FILTER_EN
  localparam int SETTLE_LEN = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int SETTLE_LEN = SYNC_STAGES + 1;
`endif
  localparam int SET_W = $clog2(SETTLE_LEN + 1);

  logic clk_s, data_s, cs_s;

  serial_line_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CLK_IDLE), .FILTER_LEN(FILTER_LEN))
    u_clk_sync (.sys_clk(sys_clk), .rst(rst), .line_i(sif.bus_clk), .line_o(clk_s));

  serial_line_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .FILTER_LEN(FILTER_LEN))
    u_data_sync (.sys_clk(sys_clk), .rst(rst), .line_i(sif.bus_data), .line_o(data_s));

  serial_line_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE), .FILTER_LEN(FILTER_LEN))
    u_cs_sync (.sys_clk(sys_clk), .rst(rst), .line_i(sif.bus_cs), .line_o(cs_s));

  state_e           state_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic             clk_dly_q;
  logic             read_sig_q, data_bit_q, frame_start_q, frame_end_q, frame_active_q;
  logic [CNT_W-1:0] bit_count_q;
  logic             overflow_q;

  logic edge_hit, cs_on;

  assign edge_hit = (SAMPLE_EDGE == EDGE_FALLING) ? (clk_dly_q & ~clk_s) : (clk_s & ~clk_dly_q);
  assign cs_on    = (cs_s != CS_IDLE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q        <= SETTLE;
      settle_cnt_q   <= '0;
      clk_dly_q      <= CLK_IDLE;
      read_sig_q     <= 1'b0;
      data_bit_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_active_q <= 1'b0;
      bit_count_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      clk_dly_q     <= clk_s;
      read_sig_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      case (state_q)
        // Let every chain flush its reset preload before edges are trusted.
        SETTLE: begin
          frame_active_q <= 1'b0;
          if (settle_cnt_q == SET_W'(SETTLE_LEN - 1)) begin
            state_q <= IDLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        // A clock edge coinciding with cs assertion is intentionally not counted.
        IDLE: begin
          if (cs_on && sif.en) begin
            state_q        <= ACTIVE;
            frame_start_q  <= 1'b1;
            frame_active_q <= 1'b1;
            bit_count_q    <= '0;
            overflow_q     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (!sif.en) begin
            state_q        <= IDLE;
            frame_active_q <= 1'b0;
          end else if (!cs_on) begin
            state_q        <= IDLE;
            frame_active_q <= 1'b0;
            frame_end_q    <= 1'b1;
          end else if (edge_hit) begin
            read_sig_q <= 1'b1;
            data_bit_q <= data_s;
            if (bit_count_q < CNT_W'(MAX_BITS)) begin
              bit_count_q <= bit_count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q        <= SETTLE;
          settle_cnt_q   <= '0;
          data_bit_q     <= 1'b0;
          frame_active_q <= 1'b0;
          bit_count_q    <= '0;
          overflow_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sif.read_sig     = read_sig_q;
  assign sif.data_bit     = data_bit_q;
  assign sif.frame_start  = frame_start_q;
  assign sif.frame_end    = frame_end_q;
  assign sif.frame_active = frame_active_q;
  assign sif.bit_count    = bit_count_q;
  assign sif.overflow     = overflow_q;

endmodule

// File: tb/tb_serial_edge_sampler.sv
// tb/tb_serial_edge_sampler.sv - directed self-checking bench for serial_edge_sampler
module tb_serial_edge_sampler;

  localparam int S  = 2;
  localparam int FL = 3;
`ifdef SERIAL_GLITCH_FILTER_EN
  localparam int LAT        = S + FL + 1;
  localparam int SETTLE_LEN = S + 1 + FL;
`else
  localparam int LAT        = S + 1;
  localparam int SETTLE_LEN = S + 1;
`endif

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst, en, bus_clk, bus_data, bus_cs;

  serial_edge_sampler_if #(.CNT_W(6)) ifa ();
  serial_edge_sampler_if #(.CNT_W(3)) ifb ();

  assign ifa.en = en;  assign ifa.bus_clk = bus_clk;  assign ifa.bus_data = bus_data;  assign ifa.bus_cs = bus_cs;
  assign ifb.en = en;  assign ifb.bus_clk = bus_clk;  assign ifb.bus_data = bus_data;  assign ifb.bus_cs = bus_cs;

  serial_edge_sampler #(.SYNC_STAGES(S), .SAMPLE_EDGE(0), .CLK_IDLE(1'b0), .CS_ACTIVE_LOW(1),
                        .MAX_BITS(32), .FILTER_LEN(FL))
    dut_a (.sys_clk(sys_clk), .rst(rst), .sif(ifa));

  serial_edge_sampler #(.SYNC_STAGES(S), .SAMPLE_EDGE(0), .CLK_IDLE(1'b0), .CS_ACTIVE_LOW(1),
                        .MAX_BITS(4), .FILTER_LEN(FL))
    dut_b (.sys_clk(sys_clk), .rst(rst), .sif(ifb));

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   rs_cyc_a[$];
  logic db_a[$];
  int   fs_a = 0, fe_a = 0, fs_b = 0;
  int   edge_cyc[$];

  always @(negedge sys_clk) begin
    if (ifa.read_sig === 1'b1) begin
      rs_cyc_a.push_back(cyc);
      db_a.push_back(ifa.data_bit);
    end
    if (ifa.frame_start === 1'b1) fs_a++;
    if (ifa.frame_end === 1'b1) fe_a++;
    if (ifb.frame_start === 1'b1) fs_b++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One bus-clock period: low phase carrying the new data, then the rising edge.
  task automatic pulse(input logic d);
    bus_data = d;
    bus_clk  = 1'b0;
    step(4);
    bus_clk = 1'b1;
    edge_cyc.push_back(cyc);
    step(4);
  endtask

  task automatic cs_assert();
    bus_cs = 1'b0;
    step(LAT + 2);
  endtask

  task automatic cs_deassert();
    bus_cs = 1'b1;
    step(LAT + 2);
  endtask

  function automatic logic [11:0] outs_a();
    return {ifa.read_sig, ifa.data_bit, ifa.frame_start, ifa.frame_end, ifa.frame_active,
            ifa.overflow, ifa.bit_count};
  endfunction

  task automatic test_reset();
    int r0;
    en = 1'b1; bus_clk = 1'b1; bus_data = 1'b0; bus_cs = 1'b1; rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++;
    if (outs_a() !== 12'h000) begin
      n_mis++; $display("FAIL reset_outs_a: got %h want 000", outs_a());
    end
    n_cmp++;
    if ({ifb.read_sig, ifb.frame_start, ifb.frame_end, ifb.frame_active, ifb.overflow, ifb.bit_count} !== 8'h00) begin
      n_mis++; $display("FAIL reset_outs_b: got nonzero bit_count=%0d", ifb.bit_count);
    end
    r0 = rs_cyc_a.size();
    step(SETTLE_LEN + 4);
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 0) begin
      n_mis++; $display("FAIL settle_no_read_sig: got %0d pulses want 0", rs_cyc_a.size() - r0);
    end
    n_cmp++;
    if (outs_a() !== 12'h000) begin
      n_mis++; $display("FAIL settle_outs: got %h want 000", outs_a());
    end
    bus_clk = 1'b0;
    step(LAT + 2);
  endtask

  task automatic test_normal_frame();
    logic [7:0] pat;
    logic [7:0] got;
    int fs0, fe0, r0;
    pat = 8'hA5;
    got = 8'h00;
    fs0 = fs_a; fe0 = fe_a; r0 = rs_cyc_a.size();
    edge_cyc.delete();
    cs_assert();
    n_cmp++;
    if (ifa.frame_active !== 1'b1) begin
      n_mis++; $display("FAIL normal_active: got %b want 1", ifa.frame_active);
    end
    for (int i = 0; i < 8; i++) pulse(pat[7-i]);
    bus_clk = 1'b0;
    step(LAT + 2);
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 8) begin
      n_mis++; $display("FAIL normal_pulses: got %0d want 8", rs_cyc_a.size() - r0);
    end
    for (int i = 0; i < 8; i++) begin
      if (r0 + i < rs_cyc_a.size()) begin
        got[7-i] = db_a[r0+i];
        n_cmp++;
        if (rs_cyc_a[r0+i] - edge_cyc[i] !== LAT) begin
          n_mis++; $display("FAIL normal_latency[%0d]: got %0d want %0d", i, rs_cyc_a[r0+i] - edge_cyc[i], LAT);
        end
      end
    end
    n_cmp++;
    if (got !== 8'hA5) begin
      n_mis++; $display("FAIL normal_data: got %h want a5", got);
    end
    n_cmp++;
    if (ifa.bit_count !== 6'd8) begin
      n_mis++; $display("FAIL normal_count: got %0d want 8", ifa.bit_count);
    end
    cs_deassert();
    n_cmp++;
    if (fs_a - fs0 !== 1 || fe_a - fe0 !== 1) begin
      n_mis++; $display("FAIL normal_delims: start %0d end %0d want 1 1", fs_a - fs0, fe_a - fe0);
    end
    n_cmp++;
    if (ifa.frame_active !== 1'b0 || ifa.bit_count !== 6'd8) begin
      n_mis++; $display("FAIL normal_hold: active %b count %0d want 0 8", ifa.frame_active, ifa.bit_count);
    end
  endtask

  task automatic test_overflow();
    int fs0;
    int exp_cnt;
    logic exp_ovf;
    cs_assert();
    n_cmp++;
    if (ifb.bit_count !== 3'd0 || ifb.overflow !== 1'b0) begin
      n_mis++; $display("FAIL ovf_clear: count %0d ovf %b want 0 0", ifb.bit_count, ifb.overflow);
    end
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1);
      step(LAT);
      exp_cnt = (i + 1 > 4) ? 4 : i + 1;
      exp_ovf = (i >= 4);
      n_cmp++;
      if (ifb.bit_count !== 3'(exp_cnt) || ifb.overflow !== exp_ovf) begin
        n_mis++; $display("FAIL ovf_edge%0d: count %0d ovf %b want %0d %b", i + 1, ifb.bit_count, ifb.overflow, exp_cnt, exp_ovf);
      end
    end
    cs_deassert();
    n_cmp++;
    if (ifb.bit_count !== 3'd4 || ifb.overflow !== 1'b1) begin
      n_mis++; $display("FAIL ovf_hold_idle: count %0d ovf %b want 4 1", ifb.bit_count, ifb.overflow);
    end
    fs0 = fs_b;
    cs_assert();
    n_cmp++;
    if (fs_b - fs0 !== 1 || ifb.bit_count !== 3'd0 || ifb.overflow !== 1'b0) begin
      n_mis++; $display("FAIL ovf_next_frame: starts %0d count %0d ovf %b want 1 0 0", fs_b - fs0, ifb.bit_count, ifb.overflow);
    end
    cs_deassert();
  endtask

  task automatic test_cs_coincident();
    int r0, fe0;
    cs_assert();
    r0 = rs_cyc_a.size(); fe0 = fe_a;
    pulse(1'b1);
    pulse(1'b0);
    bus_clk = 1'b0;
    step(4);
    bus_clk = 1'b1;
    bus_cs  = 1'b1;
    step(LAT + 3);
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 2) begin
      n_mis++; $display("FAIL coinc_pulses: got %0d want 2", rs_cyc_a.size() - r0);
    end
    n_cmp++;
    if (fe_a - fe0 !== 1 || ifa.bit_count !== 6'd2) begin
      n_mis++; $display("FAIL coinc_end: ends %0d count %0d want 1 2", fe_a - fe0, ifa.bit_count);
    end
    bus_clk = 1'b0;
    step(4);
  endtask

  task automatic test_en_drop();
    int r0, fe0;
    cs_assert();
    r0 = rs_cyc_a.size(); fe0 = fe_a;
    pulse(1'b1);
    pulse(1'b1);
    step(LAT);
    en = 1'b0;
    step(2);
    n_cmp++;
    if (ifa.frame_active !== 1'b0) begin
      n_mis++; $display("FAIL en_drop_active: got %b want 0", ifa.frame_active);
    end
    pulse(1'b1);
    step(LAT);
    cs_deassert();
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 2 || fe_a - fe0 !== 0 || ifa.bit_count !== 6'd2) begin
      n_mis++; $display("FAIL en_drop_effects: pulses %0d ends %0d count %0d want 2 0 2", rs_cyc_a.size() - r0, fe_a - fe0, ifa.bit_count);
    end
    en = 1'b1;
    bus_clk = 1'b0;
    step(4);
  endtask

  task automatic test_rst_mid_frame();
    int fs0, fe0, r0;
    cs_assert();
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    step(LAT);
    fe0 = fe_a;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++;
    if (outs_a() !== 12'h000) begin
      n_mis++; $display("FAIL rst_mid_outs: got %h want 000", outs_a());
    end
    fs0 = fs_a; r0 = rs_cyc_a.size();
    step(SETTLE_LEN + 3);
    n_cmp++;
    if (fs_a - fs0 !== 1 || fe_a - fe0 !== 0 || rs_cyc_a.size() - r0 !== 0) begin
      n_mis++; $display("FAIL rst_mid_restart: starts %0d ends %0d pulses %0d want 1 0 0", fs_a - fs0, fe_a - fe0, rs_cyc_a.size() - r0);
    end
    pulse(1'b0);
    pulse(1'b1);
    step(LAT);
    n_cmp++;
    if (ifa.bit_count !== 6'd2) begin
      n_mis++; $display("FAIL rst_mid_recount: got %0d want 2", ifa.bit_count);
    end
    cs_deassert();
    bus_clk = 1'b0;
    step(4);
  endtask

`ifdef SERIAL_GLITCH_FILTER_EN
  task automatic test_glitch();
    int r0, e;
    cs_assert();
    r0 = rs_cyc_a.size();
    bus_clk = 1'b1;
    step(2);
    bus_clk = 1'b0;
    step(10);
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 0) begin
      n_mis++; $display("FAIL glitch_short: got %0d pulses want 0", rs_cyc_a.size() - r0);
    end
    bus_clk = 1'b1;
    e = cyc;
    step(5);
    bus_clk = 1'b0;
    step(10);
    n_cmp++;
    if (rs_cyc_a.size() - r0 !== 1) begin
      n_mis++; $display("FAIL glitch_long: got %0d pulses want 1", rs_cyc_a.size() - r0);
    end else begin
      n_cmp++;
      if (rs_cyc_a[r0] - e !== 6) begin
        n_mis++; $display("FAIL glitch_latency: got %0d want 6", rs_cyc_a[r0] - e);
      end
    end
    cs_deassert();
  endtask
`endif

  initial begin
    test_reset();
    test_normal_frame();
    test_overflow();
    test_cs_coincident();
    test_en_drop();
    test_rst_mid_frame();
`ifdef SERIAL_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
